// File: rtl/divider_seq.sv
// Sequential unsigned divider: restoring radix-2, one quotient bit per clock.
// Latency: NUM_W cycles from accept to out_valid (1 cycle for divide-by-zero).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module divider_seq #(
    parameter int NUM_W = 8,
    parameter int DEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    // Numerator shifts out of the top while quotient bits shift in at the bottom,
    // so after NUM_W steps this register holds the quotient.
    logic [NUM_W-1:0] num_q;
    logic [DEN_W-1:0] den_q;
    logic [DEN_W:0]   prem;
    logic [CNT_W-1:0] cnt;
    // A zero divisor takes a single CALC cycle so its latency is fixed at one.
    logic             zero_q;

    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   diff;
    logic             qbit;
    logic [DEN_W:0]   prem_next;
    logic [NUM_W-1:0] num_next;

    // Handshake and status flags decode straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);

    // One restoring step: the partial remainder is always below the divisor, so
    // its top bit is zero before the shift and nothing is lost.
    always_comb begin
        shifted   = {prem[DEN_W-1:0], num_q[NUM_W-1]};
        diff      = shifted - {1'b0, den_q};
        qbit      = (shifted >= {1'b0, den_q});
        prem_next = qbit ? diff : shifted;
        num_next  = {num_q[NUM_W-2:0], qbit};
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            num_q       <= '0;
            den_q       <= '0;
            prem        <= '0;
            cnt         <= '0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        num_q  <= numerator;
                        den_q  <= denominator;
                        prem   <= '0;
                        zero_q <= (denominator == '0);
                        cnt    <= (denominator == '0) ? CNT_W'(1) : CNT_W'(NUM_W);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (!zero_q) begin
                        num_q <= num_next;
                        prem  <= prem_next;
                    end
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        div_by_zero <= zero_q;
                        if (zero_q) begin
                            quotient  <= '1;
                            remainder <= num_q[DEN_W-1:0];
                        end else begin
                            quotient  <= num_next;
                            remainder <= prem_next[DEN_W-1:0];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: default 8/4 instance plus a 16/8 instance.
// Expected results are queued at stimulus time and popped when out_valid appears.
// All driving and sampling happens on the falling clock edge.
module tb_divider_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, dz_a, busy_a;
    logic [7:0] num_a, quo_a;
    logic [3:0] den_a, rem_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, dz_b, busy_b;
    logic [15:0] num_b, quo_b;
    logic [7:0]  den_b, rem_b;

    divider_seq #(.NUM_W(8), .DEN_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .numerator(num_a), .denominator(den_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .quotient(quo_a), .remainder(rem_a),
        .div_by_zero(dz_a), .busy(busy_a)
    );

    divider_seq #(.NUM_W(16), .DEN_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .numerator(num_b), .denominator(den_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .quotient(quo_b), .remainder(rem_b),
        .div_by_zero(dz_b), .busy(busy_b)
    );

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int checks = 0;
    int passes = 0;

    // Queue the expected result, then present operands for one accept edge.
    task automatic send_a(input logic [7:0] n, input logic [3:0] d,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz);
        exp_t e;
        e.q = eq; e.r = er; e.dz = edz;
        sb_a.push_back(e);
        num_a = n; den_a = d; in_valid_a = 1'b1;
        checks++;
        if (in_ready_a !== 1'b1) $display("FAIL accept_ready_a: got %b want 1", in_ready_a);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] n, input logic [7:0] d,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz);
        exp_t e;
        e.q = eq; e.r = er; e.dz = edz;
        sb_b.push_back(e);
        num_b = n; den_b = d; in_valid_b = 1'b1;
        checks++;
        if (in_ready_b !== 1'b1) $display("FAIL accept_ready_b: got %b want 1", in_ready_b);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        in_valid_b = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_a(output int lat);
        lat = 0;
        while (out_valid_a !== 1'b1 && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        if (lat >= 100) begin
            checks++;
            $display("FAIL timeout_a: got no out_valid want out_valid within 100 cycles");
        end
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (out_valid_b !== 1'b1 && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        if (lat >= 100) begin
            checks++;
            $display("FAIL timeout_b: got no out_valid want out_valid within 100 cycles");
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({quo_a, rem_a, dz_a, out_valid_a, busy_a, in_ready_a} !== {8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_a: got q=%0h r=%0h dz=%b ov=%b busy=%b ir=%b want 0 0 0 0 0 1",
                     quo_a, rem_a, dz_a, out_valid_a, busy_a, in_ready_a);
        else passes++;
        checks++;
        if ({quo_b, rem_b, dz_b, out_valid_b, busy_b, in_ready_b} !== {16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_b: got q=%0h r=%0h dz=%b ov=%b busy=%b ir=%b want 0 0 0 0 0 1",
                     quo_b, rem_b, dz_b, out_valid_b, busy_b, in_ready_b);
        else passes++;
    endtask

    task automatic test_basic();
        int lat;
        exp_t e;
        out_ready_a = 1'b1;
        send_a(8'd200, 4'd7, 16'd28, 8'd4, 1'b0);
        checks++;
        if (busy_a !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_a);
        else passes++;
        wait_a(lat);
        e = sb_a.pop_front();
        checks++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d want 8", lat);
        else passes++;
        checks++;
        if (quo_a !== e.q[7:0] || rem_a !== e.r[3:0] || dz_a !== e.dz)
            $display("FAIL basic_result: got %0d r %0d dz %b want %0d r %0d dz %b",
                     quo_a, rem_a, dz_a, e.q, e.r, e.dz);
        else passes++;
        checks++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL basic_done_flags: got ir=%b busy=%b want 0 0", in_ready_a, busy_a);
        else passes++;
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0)
            $display("FAIL basic_release: got ir=%b ov=%b want 1 0", in_ready_a, out_valid_a);
        else passes++;
    endtask

    task automatic test_boundary();
        logic [7:0] tn [4] = '{8'd255, 8'd0, 8'd7, 8'd255};
        logic [3:0] td [4] = '{4'd15, 4'd5, 4'd9, 4'd1};
        logic [7:0] tq [4] = '{8'd17, 8'd0, 8'd0, 8'd255};
        logic [3:0] tr [4] = '{4'd0, 4'd0, 4'd7, 4'd0};
        int lat;
        exp_t e;
        out_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_a(tn[i], td[i], {8'd0, tq[i]}, {4'd0, tr[i]}, 1'b0);
            wait_a(lat);
            e = sb_a.pop_front();
            checks++;
            if (lat !== 8 || quo_a !== e.q[7:0] || rem_a !== e.r[3:0] || dz_a !== e.dz)
                $display("FAIL boundary_%0d: got lat %0d %0d r %0d dz %b want lat 8 %0d r %0d dz %b",
                         i, lat, quo_a, rem_a, dz_a, e.q, e.r, e.dz);
            else passes++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        exp_t e;
        out_ready_a = 1'b1;
        send_a(8'd9, 4'd0, 16'hFF, 8'd9, 1'b1);
        wait_a(lat);
        e = sb_a.pop_front();
        checks++;
        if (lat !== 1) $display("FAIL dz_latency: got %0d want 1", lat);
        else passes++;
        checks++;
        if (quo_a !== e.q[7:0] || rem_a !== e.r[3:0] || dz_a !== e.dz)
            $display("FAIL dz_result: got %0h r %0d dz %b want %0h r %0d dz %b",
                     quo_a, rem_a, dz_a, e.q, e.r, e.dz);
        else passes++;
        @(posedge clk); @(negedge clk);
        send_a(8'd10, 4'd3, 16'd3, 8'd1, 1'b0);
        wait_a(lat);
        e = sb_a.pop_front();
        checks++;
        if (lat !== 8 || quo_a !== e.q[7:0] || rem_a !== e.r[3:0] || dz_a !== e.dz)
            $display("FAIL dz_next: got lat %0d %0d r %0d dz %b want lat 8 %0d r %0d dz %b",
                     lat, quo_a, rem_a, dz_a, e.q, e.r, e.dz);
        else passes++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        out_ready_a = 1'b0;
        send_a(8'd100, 4'd6, 16'd16, 8'd4, 1'b0);
        lat = 0;
        while (out_valid_a !== 1'b1 && lat < 100) begin
            num_a = 8'($urandom); den_a = 4'($urandom);
            @(posedge clk); lat++; @(negedge clk);
        end
        checks++;
        if (lat !== 8) $display("FAIL bp_latency: got %0d want 8", lat);
        else passes++;
        e = sb_a.pop_front();
        for (int i = 0; i < 5; i++) begin
            num_a = 8'($urandom);
            checks++;
            if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 ||
                quo_a !== e.q[7:0] || rem_a !== e.r[3:0] || dz_a !== e.dz)
                $display("FAIL bp_hold_%0d: got ov=%b ir=%b %0d r %0d dz %b want 1 0 %0d r %0d dz %b",
                         i, out_valid_a, in_ready_a, quo_a, rem_a, dz_a, e.q, e.r, e.dz);
            else passes++;
            @(posedge clk); @(negedge clk);
        end
        out_ready_a = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0)
            $display("FAIL bp_release: got ir=%b ov=%b want 1 0", in_ready_a, out_valid_a);
        else passes++;
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen;
        exp_t e;
        out_ready_a = 1'b1;
        send_a(8'd200, 4'd7, 16'd28, 8'd4, 1'b0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        void'(sb_a.pop_front());
        checks++;
        if ({quo_a, rem_a, dz_a, out_valid_a, busy_a, in_ready_a} !== {8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL midreset_state: got q=%0h r=%0h dz=%b ov=%b busy=%b ir=%b want 0 0 0 0 0 1",
                     quo_a, rem_a, dz_a, out_valid_a, busy_a, in_ready_a);
        else passes++;
        seen = 0;
        repeat (12) begin
            if (out_valid_a === 1'b1) seen++;
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (seen !== 0) $display("FAIL midreset_no_result: got %0d out_valid cycles want 0", seen);
        else passes++;
        send_a(8'd50, 4'd5, 16'd10, 8'd0, 1'b0);
        wait_a(lat);
        e = sb_a.pop_front();
        checks++;
        if (lat !== 8 || quo_a !== e.q[7:0] || rem_a !== e.r[3:0] || dz_a !== e.dz)
            $display("FAIL midreset_next: got lat %0d %0d r %0d dz %b want lat 8 %0d r %0d dz %b",
                     lat, quo_a, rem_a, dz_a, e.q, e.r, e.dz);
        else passes++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_wide();
        int lat;
        exp_t e;
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] mq;
        logic [7:0]  mr;
        out_ready_b = 1'b1;
        send_b(16'd50000, 8'd251, 16'd199, 8'd51, 1'b0);
        wait_b(lat);
        e = sb_b.pop_front();
        checks++;
        if (lat !== 16 || quo_b !== e.q || rem_b !== e.r || dz_b !== e.dz)
            $display("FAIL wide_directed: got lat %0d %0d r %0d dz %b want lat 16 %0d r %0d dz %b",
                     lat, quo_b, rem_b, dz_b, e.q, e.r, e.dz);
        else passes++;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            n = 16'($urandom);
            d = (i % 97 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (d == 8'd0) begin
                mq = 16'hFFFF; mr = n[7:0];
            end else begin
                mq = n / {8'd0, d}; mr = 8'(n % {8'd0, d});
            end
            send_b(n, d, mq, mr, (d == 8'd0));
            wait_b(lat);
            e = sb_b.pop_front();
            checks++;
            if (lat !== ((d == 8'd0) ? 1 : 16) || quo_b !== e.q || rem_b !== e.r || dz_b !== e.dz)
                $display("FAIL wide_rand_%0d: %0d/%0d got lat %0d %0d r %0d dz %b want %0d r %0d dz %b",
                         i, n, d, lat, quo_b, rem_b, dz_b, e.q, e.r, e.dz);
            else passes++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid_a = 1'b0; num_a = '0; den_a = '0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; num_b = '0; den_b = '0; out_ready_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_wide();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
